// File: rtl/muldiv_hilo_unit.sv
// ============================================================================
// Module   : muldiv_hilo_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int         c_CW   = $clog2(WIDTH);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_upper;
    logic [WIDTH-1:0]   w_lower;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_div = op[1];
    assign w_signed = op[0];
    // Magnitude of the most negative value is kept as an unsigned 2^(WIDTH-1).
    assign w_a_mag  = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_b_mag  = (w_signed && B[WIDTH-1]) ? -B : B;

    assign w_upper  = r_acc[2*WIDTH-1:WIDTH];
    assign w_lower  = r_acc[WIDTH-1:0];

    // Shift-add step: conditionally add multiplicand to upper half, shift right.
    assign w_add      = {1'b0, w_upper} + ({(WIDTH+1){w_lower[0]}} & {1'b0, r_b});
    assign w_mul_next = {w_add, w_lower[WIDTH-1:1]};

    // Restoring step: sign of the trial difference selects restore vs. keep.
    assign w_shift    = {w_upper, w_lower[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_b};
    assign w_div_next = {(w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                         w_lower[WIDTH-2:0], ~w_trial[WIDTH]};

    assign w_prod_fix = r_neg_res ? -r_acc   : r_acc;
    assign w_quo_fix  = r_neg_res ? -w_lower : w_lower;
    assign w_rem_fix  = r_neg_rem ? -w_upper : w_upper;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_is_div && (B == '0)) begin
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_is_div  <= w_is_div;
                            r_neg_res <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_rem <= w_signed & A[WIDTH-1];
                            r_b       <= w_b_mag;
                            r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                            r_cnt     <= '0;
                            r_state   <= c_RUN;
                        end
                    end else begin
                        if (hi_we) r_hi <= wr_data;
                        if (lo_we) r_lo <= wr_data;
                    end
                end
                c_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(WIDTH-1)) r_state <= c_FIX;
                end
                c_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != c_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign Hi          = r_hi;
    assign Lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
// ============================================================================
// Module   : tb_muldiv_hilo_unit
// Purpose  : Directed self-checking bench for muldiv_hilo_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] Hi, Lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .busy(busy),
        .done(done), .div_by_zero(div_by_zero), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint unsigned p;
        case (o)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sb;
            2'd2:    p = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
            default: begin
                longint q = sa / sb;
                longint r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction

    // Model: an accepted op stays busy 33 cycles, then publishes its result.
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_hi   <= p_hi;
                m_lo   <= p_lo;
                m_done <= 1'b1;
            end else if (start) begin
                if (op[1] && B == 32'd0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                end else begin
                    {p_hi, p_lo} <= ref_calc(op, A, B);
                    m_left       <= 33;
                end
            end else begin
                if (hi_we) m_hi <= wr_data;
                if (lo_we) m_lo <= wr_data;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
        chk("done", {63'd0, done}, {63'd0, m_done});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
        chk("Hi", {32'd0, Hi}, {32'd0, m_hi});
        chk("Lo", {32'd0, Lo}, {32'd0, m_lo});
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat, bc;
        start_op(o, a, b);
        wait_done(lat, bc);
        chk({nm, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
        chk({nm, "_lo"}, {32'd0, Lo}, {32'd0, elo});
    endtask

    initial begin
        int lat, bc;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, Hi}, 64'd0);
        chk("rst_lo", {32'd0, Lo}, 64'd0);
        reset_n = 1'b1;

        start_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_done_latency", 64'(lat), 64'd34);
        chk("multu_hi", {32'd0, Hi}, 64'hFFFFFFFE);
        chk("multu_lo", {32'd0, Lo}, 64'h00000001);

        run_op("mult_neg",  2'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min",  2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("div_neg",   2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",      2'd2, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_ovf",   2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_op("div_mixed", 2'd3, 32'd13,       32'hFFFFFFFB, 32'd3,        32'hFFFFFFFE);

        // Simultaneous MTHI/MTLO, then separate preloads.
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both_hi", {32'd0, Hi}, 64'h5A5A);
        chk("mt_both_lo", {32'd0, Lo}, 64'h5A5A);
        hi_we = 1'b1; wr_data = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h22;
        @(negedge clk); lo_we = 1'b0;

        // Divide by zero, with a competing MTHI that start must override.
        start = 1'b1; op = 2'd2; A = 32'd7; B = 32'd0; hi_we = 1'b1; wr_data = 32'h99;
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        chk("dbz_done", {63'd0, done}, 64'd1);
        chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        chk("dbz_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("dbz_pulse_end", {63'd0, done}, 64'd0);
        chk("dbz_hi", {32'd0, Hi}, 64'h11);
        chk("dbz_lo", {32'd0, Lo}, 64'h22);

        // Start and MTHI while busy must both be ignored.
        start_op(2'd0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd2; A = 32'd9; B = 32'd3; hi_we = 1'b1; wr_data = 32'hDEAD;
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        wait_done(lat, bc);
        chk("busy_ign_lat", 64'(lat), 64'd29);
        chk("busy_ign_hi", {32'd0, Hi}, 64'h0);
        chk("busy_ign_lo", {32'd0, Lo}, 64'd12);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk); start = 1'b1; op = 2'd0; A = 32'h1234; B = 32'h5678;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, Hi}, 64'd0);
        chk("abort_lo", {32'd0, Lo}, 64'd0);
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        run_op("mult_post_rst", 2'd1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd4);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
